// File: rtl/match_resp_merger_pkg.sv
`default_nettype none
// ============================================================================
// Module : match_resp_merger_pkg
// Brief  : Shared default sizes and width helpers for the response merger.
// Rev    : 1.0 - initial release
// ============================================================================
package match_resp_merger_pkg;

  localparam int DEF_SLOT_LOG2 = 2;
  localparam int DEF_LAZY_LEN  = 4;
  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_LEN_BITS  = 6;

  // Index width for n items, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/match_resp_merger_if.sv
`default_nettype none
// ============================================================================
// Module : match_resp_merger_if
// Brief  : Window, response and result buses of the response merger.
// Rev    : 1.0 - initial release
// ============================================================================
interface match_resp_merger_if
  import match_resp_merger_pkg::*;
#(
  parameter int SLOT_LOG2 = DEF_SLOT_LOG2,
  parameter int LAZY_LEN  = DEF_LAZY_LEN,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int LEN_BITS  = DEF_LEN_BITS
) ();

  localparam int LANE_BITS = min1_clog2(LAZY_LEN);
  localparam int CH_BITS   = min1_clog2(NUM_CH);

  logic                           win_valid;
  logic                           win_ready;
  logic [LAZY_LEN*NUM_CH-1:0]     win_route_map;
  logic [SLOT_LOG2-1:0]           win_tag;
  logic [NUM_CH-1:0]              resp_valid;
  logic [NUM_CH-1:0]              resp_ready;
  logic [NUM_CH*SLOT_LOG2-1:0]    resp_tag;
  logic [NUM_CH*LANE_BITS-1:0]    resp_lane;
  logic [NUM_CH*LEN_BITS-1:0]     resp_len;
  logic                           out_valid;
  logic                           out_ready;
  logic [LAZY_LEN*LEN_BITS-1:0]   out_len;
  logic [LAZY_LEN*CH_BITS-1:0]    out_ch;
  logic                           err;

  modport master (
    output win_valid, win_route_map, resp_valid, resp_tag, resp_lane, resp_len, out_ready,
    input  win_ready, win_tag, resp_ready, out_valid, out_len, out_ch, err
  );

  modport slave (
    input  win_valid, win_route_map, resp_valid, resp_tag, resp_lane, resp_len, out_ready,
    output win_ready, win_tag, resp_ready, out_valid, out_len, out_ch, err
  );

endinterface
`default_nettype wire

// File: rtl/match_resp_best_sel.sv
`default_nettype none
// ============================================================================
// Module : match_resp_best_sel
// Brief  : Combinational per-lane reducer: longest match wins, ties go to the
//          lowest channel; a zero length never displaces anything.
// Rev    : 1.0 - initial release
// ============================================================================
module match_resp_best_sel #(
  parameter int NUM_CAND = 5,
  parameter int LEN_BITS = 6,
  parameter int CH_BITS  = 2
) (
  input  logic [NUM_CAND*LEN_BITS-1:0] cand_len,
  input  logic [NUM_CAND*CH_BITS-1:0]  cand_ch,
  input  logic [NUM_CAND-1:0]          cand_valid,
  output logic [LEN_BITS-1:0]          best_len,
  output logic [CH_BITS-1:0]           best_ch
);

  logic [LEN_BITS-1:0] c_len;
  logic [CH_BITS-1:0]  c_ch;

  // Fold all valid candidates into one winner; the rule is order independent.
  always_comb begin
    best_len = '0;
    best_ch  = '0;
    c_len    = '0;
    c_ch     = '0;
    for (int k = 0; k < NUM_CAND; k++) begin
      c_len = cand_len[k*LEN_BITS +: LEN_BITS];
      c_ch  = cand_ch[k*CH_BITS +: CH_BITS];
      if (cand_valid[k] &&
          ((c_len > best_len) ||
           ((c_len == best_len) && (best_len != '0) && (c_ch < best_ch)))) begin
        best_len = c_len;
        best_ch  = c_ch;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/match_resp_merger.sv
`default_nettype none
// ============================================================================
// Module : match_resp_merger
// Brief  : Reorder buffer collecting per-channel match responses per window
//          and emitting per-lane best length/channel in allocation order.
// Rev    : 1.0 - initial release
// ============================================================================
module match_resp_merger
  import match_resp_merger_pkg::*;
#(
  parameter int SLOT_LOG2 = DEF_SLOT_LOG2,
  parameter int LAZY_LEN  = DEF_LAZY_LEN,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int LEN_BITS  = DEF_LEN_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  match_resp_merger_if.slave   bus
);

  localparam int NSLOT     = 1 << SLOT_LOG2;
  localparam int LANE_BITS = min1_clog2(LAZY_LEN);
  localparam int CH_BITS   = min1_clog2(NUM_CH);
  localparam int MAP_BITS  = LAZY_LEN * NUM_CH;
  localparam int IDX_BITS  = min1_clog2(MAP_BITS);
  localparam logic [SLOT_LOG2:0] SLOTS_FULL = (SLOT_LOG2+1)'(NSLOT);

  // Slot storage
  logic                 slot_valid [NSLOT];
  logic [MAP_BITS-1:0]  slot_pend  [NSLOT];
  logic [LEN_BITS-1:0]  slot_len   [NSLOT][LAZY_LEN];
  logic [CH_BITS-1:0]   slot_ch    [NSLOT][LAZY_LEN];

  logic [SLOT_LOG2-1:0] head;
  logic [SLOT_LOG2-1:0] tail;
  logic [SLOT_LOG2:0]   count;
  logic                 err_q;

  // Decoded responses
  logic [SLOT_LOG2-1:0] rtag [NUM_CH];
  logic [LANE_BITS-1:0] rlane[NUM_CH];
  logic [LEN_BITS-1:0]  rlen [NUM_CH];
  logic [IDX_BITS-1:0]  bidx [NUM_CH];
  logic [NUM_CH-1:0]    rok;
  logic [NUM_CH-1:0]    rbad;

  logic [MAP_BITS-1:0]  clr     [NSLOT];
  logic [LEN_BITS-1:0]  nxt_len [NSLOT][LAZY_LEN];
  logic [CH_BITS-1:0]   nxt_ch  [NSLOT][LAZY_LEN];

  logic can_accept;
  logic head_done;
  logic accept;
  logic retire;

  assign can_accept = (count != SLOTS_FULL);
  assign head_done  = slot_valid[head] && (slot_pend[head] == '0);
  assign accept     = bus.win_valid && can_accept;
  assign retire     = head_done && bus.out_ready;

  // Split response buses and classify each response as usable or erroneous.
  always_comb begin
    for (int j = 0; j < NUM_CH; j++) begin
      rtag[j]  = bus.resp_tag[j*SLOT_LOG2 +: SLOT_LOG2];
      rlane[j] = bus.resp_lane[j*LANE_BITS +: LANE_BITS];
      rlen[j]  = bus.resp_len[j*LEN_BITS +: LEN_BITS];
      bidx[j]  = IDX_BITS'(int'(rlane[j]) * NUM_CH + j);
      rok[j]   = 1'b0;
      if (bus.resp_valid[j] && (int'(rlane[j]) < LAZY_LEN) && slot_valid[rtag[j]])
        rok[j] = slot_pend[rtag[j]][bidx[j]];
      rbad[j]  = bus.resp_valid[j] && !rok[j];
    end
  end

  // Pending bits retired by this cycle's usable responses.
  always_comb begin
    for (int s = 0; s < NSLOT; s++) clr[s] = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (rok[j]) clr[rtag[j]][bidx[j]] = 1'b1;
    end
  end

  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    for (genvar i = 0; i < LAZY_LEN; i++) begin : g_lane
      logic [(NUM_CH+1)*LEN_BITS-1:0] cand_len;
      logic [(NUM_CH+1)*CH_BITS-1:0]  cand_ch;
      logic [NUM_CH:0]                cand_valid;

      // Stored result is candidate 0; each response hitting this slot/lane joins it.
      always_comb begin
        cand_len[LEN_BITS-1:0] = slot_len[s][i];
        cand_ch[CH_BITS-1:0]   = slot_ch[s][i];
        cand_valid[0]          = 1'b1;
        for (int j = 0; j < NUM_CH; j++) begin
          cand_len[(j+1)*LEN_BITS +: LEN_BITS] = rlen[j];
          cand_ch[(j+1)*CH_BITS +: CH_BITS]    = CH_BITS'(j);
          cand_valid[j+1] = rok[j] && (rtag[j] == SLOT_LOG2'(s)) && (int'(rlane[j]) == i);
        end
      end

      match_resp_best_sel #(
        .NUM_CAND (NUM_CH + 1),
        .LEN_BITS (LEN_BITS),
        .CH_BITS  (CH_BITS)
      ) u_sel (
        .cand_len   (cand_len),
        .cand_ch    (cand_ch),
        .cand_valid (cand_valid),
        .best_len   (nxt_len[s][i]),
        .best_ch    (nxt_ch[s][i])
      );
    end
  end

  // Slot array, pointers, occupancy and sticky error update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err_q <= 1'b0;
      for (int s = 0; s < NSLOT; s++) begin
        slot_valid[s] <= 1'b0;
        slot_pend[s]  <= '0;
        for (int i = 0; i < LAZY_LEN; i++) begin
          slot_len[s][i] <= '0;
          slot_ch[s][i]  <= '0;
        end
      end
    end else begin
      for (int s = 0; s < NSLOT; s++) begin
        slot_pend[s] <= slot_pend[s] & ~clr[s];
        for (int i = 0; i < LAZY_LEN; i++) begin
          slot_len[s][i] <= nxt_len[s][i];
          slot_ch[s][i]  <= nxt_ch[s][i];
        end
      end
      if (retire) begin
        slot_valid[head] <= 1'b0;
        head             <= head + SLOT_LOG2'(1);
      end
      // The tail slot is never valid, so no response can collide with this write.
      if (accept) begin
        slot_valid[tail] <= 1'b1;
        slot_pend[tail]  <= bus.win_route_map;
        for (int i = 0; i < LAZY_LEN; i++) begin
          slot_len[tail][i] <= '0;
          slot_ch[tail][i]  <= '0;
        end
        tail <= tail + SLOT_LOG2'(1);
      end
      count <= count + (SLOT_LOG2+1)'(accept) - (SLOT_LOG2+1)'(retire);
      if (|rbad) err_q <= 1'b1;
    end
  end

  // Head-slot result presentation.
  always_comb begin
    bus.out_len = '0;
    bus.out_ch  = '0;
    for (int i = 0; i < LAZY_LEN; i++) begin
      bus.out_len[i*LEN_BITS +: LEN_BITS] = slot_len[head][i];
      bus.out_ch[i*CH_BITS +: CH_BITS]    = slot_ch[head][i];
    end
  end

  assign bus.win_ready  = can_accept;
  assign bus.win_tag    = tail;
  assign bus.resp_ready = '1;
  assign bus.out_valid  = head_done;
  assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_match_resp_merger.sv
`default_nettype none
// ============================================================================
// Module : tb_match_resp_merger
// Brief  : Directed and random self-checking bench for match_resp_merger.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_match_resp_merger;

  localparam int SL = 2;
  localparam int LL = 4;
  localparam int NC = 4;
  localparam int LB = 6;
  localparam int CB = 2;
  localparam int NB = 2;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  match_resp_merger_if #(.SLOT_LOG2(SL), .LAZY_LEN(LL), .NUM_CH(NC), .LEN_BITS(LB)) bus ();

  match_resp_merger #(.SLOT_LOG2(SL), .LAZY_LEN(LL), .NUM_CH(NC), .LEN_BITS(LB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus state
  logic          win_valid;
  logic [LL*NC-1:0] win_map;
  logic          out_ready;
  logic          rv [NC];
  int            rt [NC];
  int            rl [NC];
  int            rn [NC];

  // Reference model: slots hold the received length per (lane, channel)
  bit m_valid [NS];
  bit m_pend  [NS][LL][NC];
  int m_len   [NS][LL][NC];
  int m_head, m_tail, m_count;
  bit m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int best_len(input int s, input int l);
    int b = 0;
    for (int c = 0; c < NC; c++) if (m_len[s][l][c] > b) b = m_len[s][l][c];
    return b;
  endfunction

  function automatic int best_ch(input int s, input int l);
    int b = 0;
    int bc = 0;
    for (int c = 0; c < NC; c++) if (m_len[s][l][c] > b) begin b = m_len[s][l][c]; bc = c; end
    return bc;
  endfunction

  function automatic bit m_done(input int s);
    bit d = m_valid[s];
    for (int l = 0; l < LL; l++)
      for (int c = 0; c < NC; c++) if (m_pend[s][l][c]) d = 1'b0;
    return d;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < NS; s++) begin
      m_valid[s] = 1'b0;
      for (int l = 0; l < LL; l++)
        for (int c = 0; c < NC; c++) begin m_pend[s][l][c] = 1'b0; m_len[s][l][c] = 0; end
    end
    m_head = 0; m_tail = 0; m_count = 0; m_err = 1'b0;
  endtask

  task automatic check_outputs();
    logic [LL*LB-1:0] e_len;
    logic [LL*CB-1:0] e_ch;
    e_len = '0;
    e_ch  = '0;
    for (int l = 0; l < LL; l++) begin
      e_len[l*LB +: LB] = LB'(best_len(m_head, l));
      e_ch[l*CB +: CB]  = CB'(best_ch(m_head, l));
    end
    check("win_ready", bus.win_ready, m_count != NS);
    check("win_tag", bus.win_tag, m_tail);
    check("resp_ready", bus.resp_ready, {NC{1'b1}});
    check("out_valid", bus.out_valid, m_done(m_head));
    check("out_len", bus.out_len, e_len);
    check("out_ch", bus.out_ch, e_ch);
    check("err", bus.err, m_err);
  endtask

  task automatic idle();
    win_valid = 1'b0;
    win_map   = '0;
    out_ready = 1'b0;
    for (int j = 0; j < NC; j++) begin rv[j] = 1'b0; rt[j] = 0; rl[j] = 0; rn[j] = 0; end
  endtask

  task automatic resp(input int j, input int tag, input int lane, input int len);
    rv[j] = 1'b1; rt[j] = tag; rl[j] = lane; rn[j] = len;
  endtask

  // Drive inputs, advance the model by one edge, then compare every output.
  task automatic tick();
    bit acc;
    bit ret;
    bus.win_valid     = win_valid;
    bus.win_route_map = win_map;
    bus.out_ready     = out_ready;
    for (int j = 0; j < NC; j++) begin
      bus.resp_valid[j]         = rv[j];
      bus.resp_tag[j*SL +: SL]  = SL'(rt[j]);
      bus.resp_lane[j*NB +: NB] = NB'(rl[j]);
      bus.resp_len[j*LB +: LB]  = LB'(rn[j]);
    end
    if (!rst_n) begin
      m_reset();
    end else begin
      acc = win_valid && (m_count != NS);
      ret = m_done(m_head) && out_ready;
      for (int j = 0; j < NC; j++) begin
        if (rv[j]) begin
          if (!m_valid[rt[j]] || !m_pend[rt[j]][rl[j]][j]) m_err = 1'b1;
          else begin
            m_pend[rt[j]][rl[j]][j] = 1'b0;
            m_len[rt[j]][rl[j]][j]  = rn[j];
          end
        end
      end
      if (ret) begin m_valid[m_head] = 1'b0; m_head = (m_head + 1) % NS; end
      if (acc) begin
        m_valid[m_tail] = 1'b1;
        for (int l = 0; l < LL; l++)
          for (int c = 0; c < NC; c++) begin
            m_pend[m_tail][l][c] = win_map[l*NC + c];
            m_len[m_tail][l][c]  = 0;
          end
        m_tail = (m_tail + 1) % NS;
      end
      m_count = m_count + int'(acc) - int'(ret);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic accept_win(input logic [LL*NC-1:0] map);
    idle();
    win_valid = 1'b1;
    win_map   = map;
    tick();
    idle();
  endtask

  task automatic lane1_case(input int order);
    int t;
    t = m_tail;
    accept_win(16'h00E0);
    case (order)
      0: begin
        resp(3, t, 1, 5); tick(); idle();
        resp(1, t, 1, 9); tick(); idle();
        resp(2, t, 1, 9); tick(); idle();
      end
      1: begin
        resp(1, t, 1, 9); resp(2, t, 1, 9); resp(3, t, 1, 5); tick(); idle();
      end
      2: begin
        resp(2, t, 1, 9); tick(); idle();
        resp(1, t, 1, 9); resp(3, t, 1, 5); tick(); idle();
      end
      default: begin
        resp(2, t, 1, 9); tick(); idle();
        resp(3, t, 1, 5); tick(); idle();
        resp(1, t, 1, 9); tick(); idle();
      end
    endcase
    check("lane1_valid", bus.out_valid, 1);
    check("lane1_len", bus.out_len[LB +: LB], 9);
    check("lane1_ch", bus.out_ch[CB +: CB], 1);
    out_ready = 1'b1;
    tick();
    idle();
  endtask

  logic [LL*LB-1:0] held_len;
  logic [LL*CB-1:0] held_ch;

  initial begin
    m_reset();
    idle();

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_win_ready", bus.win_ready, 1);
    check("rst_win_tag", bus.win_tag, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_len", bus.out_len, 0);
    check("rst_err", bus.err, 0);

    // Single lane, single channel
    accept_win(16'h0001);
    check("t1_pending", bus.out_valid, 0);
    resp(0, 0, 0, 7);
    tick();
    idle();
    check("t1_valid", bus.out_valid, 1);
    check("t1_len", bus.out_len, 24'd7);
    check("t1_ch", bus.out_ch, 0);
    out_ready = 1'b1;
    tick();
    idle();

    // Lane 1 over three channels, several arrival orders
    for (int o = 0; o < 4; o++) lane1_case(o);

    // Fill all slots, reject extra window, wrap the tag
    do_reset();
    for (int k = 0; k < NS; k++) accept_win(16'h0001);
    check("full_ready", bus.win_ready, 0);
    win_valid = 1'b1;
    tick();
    tick();
    idle();
    check("full_tag", bus.win_tag, 0);
    resp(0, 0, 0, 3);
    tick();
    idle();
    out_ready = 1'b1;
    tick();
    idle();
    check("wrap_ready", bus.win_ready, 1);
    check("wrap_tag", bus.win_tag, 0);
    resp(0, 1, 0, 4);
    tick();
    idle();
    win_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    idle();
    check("acc_ret_ready", bus.win_ready, 1);
    check("acc_ret_tag", bus.win_tag, 1);
    accept_win(16'h0000);
    check("refull_ready", bus.win_ready, 0);

    // Out-of-order completion, in-order release, stall holds outputs
    do_reset();
    accept_win(16'h0001);
    accept_win(16'h0002);
    resp(1, 1, 0, 6);
    tick();
    idle();
    tick();
    check("ooo_hold", bus.out_valid, 0);
    resp(0, 0, 0, 2);
    tick();
    idle();
    check("ooo_head_valid", bus.out_valid, 1);
    check("ooo_head_len", bus.out_len, 24'd2);
    held_len = bus.out_len;
    held_ch  = bus.out_ch;
    for (int k = 0; k < 3; k++) tick();
    check("stall_len", bus.out_len, held_len);
    check("stall_ch", bus.out_ch, held_ch);
    out_ready = 1'b1;
    tick();
    idle();
    check("ooo_second_len", bus.out_len, 24'd6);
    check("ooo_second_ch", bus.out_ch, 8'd1);
    out_ready = 1'b1;
    tick();
    idle();

    // Protocol errors: unallocated tag, duplicate, unrouted
    do_reset();
    accept_win(16'h0001);
    resp(0, 2, 0, 5);
    tick();
    idle();
    check("err_unalloc", bus.err, 1);
    resp(0, 0, 0, 5);
    tick();
    idle();
    resp(0, 0, 0, 9);
    resp(1, 0, 0, 3);
    tick();
    idle();
    check("err_sticky", bus.err, 1);
    check("err_no_change", bus.out_len, 24'd5);
    do_reset();
    check("err_cleared", bus.err, 0);
    check("slots_cleared", bus.out_valid, 0);

    // All-zero route map
    accept_win(16'h0000);
    check("zero_valid", bus.out_valid, 1);
    check("zero_len", bus.out_len, 0);
    out_ready = 1'b1;
    tick();
    idle();

    // Random legal traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      win_valid = ($urandom_range(0, 1) == 1);
      win_map   = ($urandom_range(0, 3) == 0) ? '0 : (LL*NC)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < NC; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int tr = 0; tr < 4; tr++) begin
            int s;
            int l;
            s = $urandom_range(0, NS - 1);
            l = $urandom_range(0, LL - 1);
            if (!rv[j] && m_valid[s] && m_pend[s][l][j]) resp(j, s, l, $urandom_range(0, 7));
          end
        end
      end
      tick();
    end

    // Random unrestricted traffic including erroneous responses
    do_reset();
    for (int cyc = 0; cyc < 100; cyc++) begin
      idle();
      win_valid = ($urandom_range(0, 1) == 1);
      win_map   = (LL*NC)'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      for (int j = 0; j < NC; j++)
        if ($urandom_range(0, 2) == 0)
          resp(j, $urandom_range(0, NS - 1), $urandom_range(0, LL - 1), $urandom_range(0, 63));
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
